// File: rtl/life_pkg.sv
`default_nettype none
// life_pkg: FSM state encoding, default grid geometry and the neighbour-count helper. Rev 1.0
package life_pkg;

  localparam int DEF_ROWS  = 8;
  localparam int DEF_COLS  = 8;
  localparam int DEF_GEN_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [3:0] count_live(input logic [7:0] bits);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, bits[i]};
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/life_cell.sv
`default_nettype none
// life_cell: one cell of the grid, mapping 8 neighbour bits plus its own state to the next state. Rev 1.0
module life_cell
  import life_pkg::*;
(
  input  logic [7:0] nbrs,
  input  logic       alive,
  output logic       next_alive
);

  logic [3:0] live_cnt;

  assign live_cnt   = count_live(nbrs);
  assign next_alive = (live_cnt == 4'd3) || ((live_cnt == 4'd2) && alive);

endmodule
`default_nettype wire

// File: rtl/life_engine.sv
`default_nettype none
// life_engine: Game of Life engine computing one generation per clock, with step/run control.
// Define LIFE_TORUS_EN for toroidal edges; by default out-of-grid neighbours are dead. Rev 1.0
module life_engine
  import life_pkg::*;
#(
  parameter int ROWS  = DEF_ROWS,
  parameter int COLS  = DEF_COLS,
  parameter int GEN_W = DEF_GEN_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_en,
  input  logic [ROWS*COLS-1:0] load_grid,
  input  logic                 step,
  input  logic                 run,
  input  logic [GEN_W-1:0]     max_gen,
  output logic [ROWS*COLS-1:0] grid_q,
  output logic [GEN_W-1:0]     gen_count,
  output logic                 busy,
  output logic                 stable,
  output logic                 extinct,
  output logic                 done
);

  localparam int CELLS = ROWS * COLS;
`ifdef LIFE_TORUS_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic [CELLS-1:0] next_grid;
  state_t           state;
  state_t           state_nxt;
  logic             upd;
  logic             set_done;
  logic             cap_limit;
  logic [GEN_W-1:0] gen_inc;
  logic [GEN_W-1:0] limit_val;
  logic             limit_on;

  // Neighbour indices are always computed wrapped; the *_OK flags kill edge neighbours when not wrapping.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int RU = (r == 0) ? ROWS - 1 : r - 1;
      localparam int RD = (r == ROWS - 1) ? 0 : r + 1;
      localparam int CL = (c == 0) ? COLS - 1 : c - 1;
      localparam int CR = (c == COLS - 1) ? 0 : c + 1;
      localparam bit UP_OK = WRAP || (r != 0);
      localparam bit DN_OK = WRAP || (r != ROWS - 1);
      localparam bit LF_OK = WRAP || (c != 0);
      localparam bit RT_OK = WRAP || (c != COLS - 1);

      logic [7:0] nbrs;

      assign nbrs[0] = (UP_OK && LF_OK) ? grid_q[RU*COLS + CL] : 1'b0;
      assign nbrs[1] = UP_OK            ? grid_q[RU*COLS + c]  : 1'b0;
      assign nbrs[2] = (UP_OK && RT_OK) ? grid_q[RU*COLS + CR] : 1'b0;
      assign nbrs[3] = LF_OK            ? grid_q[r*COLS + CL]  : 1'b0;
      assign nbrs[4] = RT_OK            ? grid_q[r*COLS + CR]  : 1'b0;
      assign nbrs[5] = (DN_OK && LF_OK) ? grid_q[RD*COLS + CL] : 1'b0;
      assign nbrs[6] = DN_OK            ? grid_q[RD*COLS + c]  : 1'b0;
      assign nbrs[7] = (DN_OK && RT_OK) ? grid_q[RD*COLS + CR] : 1'b0;

      life_cell u_cell (
        .nbrs       (nbrs),
        .alive      (grid_q[r*COLS + c]),
        .next_alive (next_grid[r*COLS + c])
      );
    end
  end

  assign stable  = (next_grid == grid_q);
  assign extinct = (grid_q == '0);
  assign busy    = (state == ST_RUN);
  assign gen_inc = (&gen_count) ? gen_count : gen_count + GEN_W'(1);

  always_comb begin
    state_nxt = state;
    upd       = 1'b0;
    set_done  = 1'b0;
    cap_limit = 1'b0;
    if (load_en) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (run) begin
            state_nxt = ST_RUN;
            cap_limit = 1'b1;
          end else if (step) begin
            upd      = 1'b1;
            set_done = 1'b1;
          end
        end
        ST_RUN: begin
          if (!run) begin
            state_nxt = ST_IDLE;
          end else if (stable || extinct) begin
            state_nxt = ST_DONE;
            set_done  = 1'b1;
          end else begin
            upd = 1'b1;
            if (limit_on && (gen_inc == limit_val)) begin
              state_nxt = ST_DONE;
              set_done  = 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (!run) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // The run limit is frozen at RUN entry; a limit already reached or passed disables the count stop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grid_q    <= '0;
      gen_count <= '0;
      done      <= 1'b0;
      limit_val <= '0;
      limit_on  <= 1'b0;
    end else begin
      done <= set_done;
      if (load_en) begin
        grid_q    <= load_grid;
        gen_count <= '0;
      end else if (upd) begin
        grid_q    <= next_grid;
        gen_count <= gen_inc;
      end
      if (cap_limit) begin
        limit_val <= max_gen;
        limit_on  <= (max_gen > gen_count);
      end
    end
  end

endmodule
`default_nettype wire
